// File: rtl/lock_sequencer.sv
// Three-byte combination lock: synchronized push-button entry, a one-cycle compare,
// wrong-code lockout timer and in-field passcode reprogramming.
module lock_sequencer #(
  parameter logic [23:0] CODE_DEFAULT   = 24'h49_A3_07,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       submit,
  input  logic [7:0] code_in,
  input  logic       prog,
  input  logic       relock,
  output logic       unlocked,
  output logic       lockout,
  output logic       programming,
  output logic [1:0] attempts_left,
  output logic [1:0] stage
);
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam logic [1:0]    MAX_A  = 2'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] T_LOAD = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]    warm_q, warm_d;
  logic          armed_q, armed_d, pulse_q, pulse_d;
  logic [1:0]    stage_q, stage_d, att_q, att_d;
  logic [23:0]   code_q, code_d, entry_q, entry_d, shadow_q, shadow_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlocked_q, unlocked_d, lockout_q, lockout_d, prog_q, prog_d;

  // Byte index 0 is the most significant byte (entered first).
  function automatic logic [23:0] put_byte(input logic [23:0] v, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [23:0] r;
    r = v;
    case (idx)
      2'd0:    r[23:16] = b;
      2'd1:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  always_comb begin
    sync1_d  = submit;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    // Edges are accepted only after the synchronized level has been seen low once
    // the pipeline holds real samples, so a button held through reset stays quiet.
    warm_d   = {warm_q[0], 1'b1};
    armed_d  = armed_q | (warm_q[1] & ~sync2_q);
    pulse_d  = sync2_q & ~prev_q & armed_q;
    state_d  = state_q;
    stage_d  = stage_q;
    att_d    = att_q;
    code_d   = code_q;
    entry_d  = entry_q;
    shadow_d = shadow_q;
    timer_d  = timer_q;
    case (state_q)
      ENTRY: if (pulse_q) begin
        entry_d = put_byte(entry_q, stage_q, code_in);
        if (stage_q == 2'd2) begin
          stage_d = 2'd0;
          state_d = CHECK;
        end else stage_d = stage_q + 2'd1;
      end
      CHECK: if (entry_q == code_q) begin
        state_d = OPEN;
        att_d   = MAX_A;
      end else if (att_q > 2'd1) begin
        att_d   = att_q - 2'd1;
        state_d = ENTRY;
      end else begin
        att_d   = 2'd0;
        state_d = LOCKOUT;
        timer_d = T_LOAD;
      end
      OPEN: if (relock) state_d = ENTRY;
        else if (pulse_q && prog) begin
          state_d = PROGRAM;
          stage_d = 2'd0;
        end
      PROGRAM: if (relock) begin
        state_d = ENTRY;
        stage_d = 2'd0;
      end else if (pulse_q) begin
        shadow_d = put_byte(shadow_q, stage_q, code_in);
        if (stage_q == 2'd2) begin
          code_d  = put_byte(shadow_q, 2'd2, code_in);
          stage_d = 2'd0;
          state_d = ENTRY;
        end else stage_d = stage_q + 2'd1;
      end
      LOCKOUT: if (timer_q == '0) begin
        state_d = ENTRY;
        att_d   = MAX_A;
      end else timer_d = timer_q - TW'(1);
      default: state_d = ENTRY;
    endcase
    unlocked_d = (state_d == OPEN);
    lockout_d  = (state_d == LOCKOUT);
    prog_d     = (state_d == PROGRAM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ENTRY;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      warm_q     <= 2'b00;
      armed_q    <= 1'b0;
      pulse_q    <= 1'b0;
      stage_q    <= 2'd0;
      att_q      <= MAX_A;
      code_q     <= CODE_DEFAULT;
      entry_q    <= '0;
      shadow_q   <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      warm_q     <= warm_d;
      armed_q    <= armed_d;
      pulse_q    <= pulse_d;
      stage_q    <= stage_d;
      att_q      <= att_d;
      code_q     <= code_d;
      entry_q    <= entry_d;
      shadow_q   <= shadow_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      prog_q     <= prog_d;
    end
  end

  assign unlocked      = unlocked_q;
  assign lockout       = lockout_q;
  assign programming   = prog_q;
  assign attempts_left = att_q;
  assign stage         = stage_q;
endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter: CODE_DEFAULT, 24'h49_A3_07, passcode loaded at reset; byte 2 is entered first.
REQ-002 Parameter: MAX_ATTEMPTS, 3, wrong-code tries allowed before lockout; legal range 1..3.
REQ-003 Parameter: LOCKOUT_CYCLES, 50_000_000, lockout duration in clk cycles; legal range >= 2.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 submit  input  1  raw push-button level, asynchronous to clk.
REQ-007 code_in  input  8  switch byte, sampled on the submit pulse.
REQ-008 prog  input  1  synchronous level; requests passcode change while unlocked.
REQ-009 relock  input  1  synchronous level; returns the lock to the locked state.
REQ-010 unlocked  output  1  high only in state OPEN.
REQ-011 lockout  output  1  high only in state LOCKOUT.
REQ-012 programming  output  1  high only in state PROGRAM.
REQ-013 attempts_left  output  2  remaining wrong-code tries.
REQ-014 stage  output  2  bytes captured in the current 3-byte sequence, 0..2.

Function
REQ-015 submit shall pass through a 2-FF synchronizer followed by a rising-edge detector, giving exactly one 1-cycle submit_pulse per low-to-high transition, 3 clk cycles after the transition.
REQ-016 States: ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT. All outputs are registered and derived from the state and counters.
REQ-017 ENTRY, on submit_pulse:
- store code_in in entry byte (2 - stage);
- increment stage;
- on the third pulse, clear stage to 0 and go to CHECK on the next edge.
REQ-018 CHECK shall last exactly 1 cycle and compare the 24-bit entry against the stored code:
- match: go to OPEN; load attempts_left = MAX_ATTEMPTS;
- mismatch with attempts_left > 1: decrement attempts_left; go to ENTRY;
- mismatch with attempts_left == 1: set attempts_left = 0; go to LOCKOUT; load timer = LOCKOUT_CYCLES - 1.
REQ-019 unlocked shall assert on the clock edge that ends the CHECK cycle, 1 cycle after the third pulse.
REQ-020 LOCKOUT shall decrement the timer every cycle and ignore all submit pulses.
- Timer == 0: go to ENTRY; load attempts_left = MAX_ATTEMPTS.
- lockout stays high for exactly LOCKOUT_CYCLES cycles.
REQ-021 OPEN:
- relock = 1: go to ENTRY.
- else submit_pulse with prog = 1: go to PROGRAM with stage = 0; the byte is not captured.
- submit_pulse with prog = 0: ignored.
REQ-022 PROGRAM:
- each submit_pulse captures code_in into shadow byte (2 - stage) and increments stage;
- on the third pulse, copy the shadow to the stored code in one cycle, clear stage, go to ENTRY.
REQ-023 In PROGRAM, relock = 1 shall abort: stored code unchanged, stage cleared, go to ENTRY; relock wins over a same-cycle submit_pulse.
REQ-024 relock and prog shall be ignored in ENTRY, CHECK and LOCKOUT.
REQ-025 Timer width shall be $clog2(LOCKOUT_CYCLES); no counter may wrap, and attempts_left shall never decrement below 0.

Reset
REQ-026 rst low shall immediately force, asynchronously:
- state = ENTRY, stage = 0, attempts_left = MAX_ATTEMPTS;
- stored code = CODE_DEFAULT, entry and shadow = 0, timer = 0;
- synchronizer and edge-detector flops = 0;
- unlocked, lockout, programming = 0.
REQ-027 Reset during LOCKOUT, PROGRAM or a partial entry shall discard all progress; a partially programmed code is never committed.
REQ-028 A submit held high across reset release shall not produce a pulse until it goes low and then high again.

Verification
REQ-029 Reset, then enter 49, A3, 07 -> unlocked = 1 one cycle after the third pulse; attempts_left = 3.
REQ-030 Enter 00,00,00 three times -> attempts_left steps 2, 1, 0; lockout = 1 for exactly LOCKOUT_CYCLES (use 16); presses during lockout ignored; then attempts_left = 3, state ENTRY.
REQ-031 Unlock, press with prog = 1, enter 11, 22, 33 -> programming drops and state is ENTRY; 49,A3,07 is rejected; 11,22,33 unlocks.
REQ-032 Unlock, enter PROGRAM, enter 2 bytes, assert relock -> old code still unlocks; stage = 0.
REQ-033 Assert rst mid-lockout and mid-entry (stage = 2) -> all outputs at reset values that same cycle; the default code works afterwards.
REQ-034 In OPEN, relock and submit_pulse in the same cycle with prog = 1 -> state ENTRY; programming stays 0.
